// File: rtl/ctrl_pkt_pkg.sv
// Control packet header layout and arbiter FSM encodings shared by the
// configuration-path arbiter.
package ctrl_pkt_pkg;

   localparam int unsigned ETH_TYPE_LSB = 128;
   localparam int unsigned PROTO_LSB    = 216;
   localparam int unsigned UDP_PORT_LSB = 320;
   localparam int unsigned MOD_ID_LSB   = 368;
   localparam int unsigned RESV_LSB     = 380;
   localparam int unsigned INDEX_LSB    = 384;

   localparam logic [15:0] ETH_TYPE_VAL = 16'h0008;
   localparam logic [7:0]  PROTO_VAL    = 8'h11;
   localparam logic [3:0]  RESV_VAL     = 4'b0001;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_PLD  = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

endpackage

// File: rtl/ctrl_cfg_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set valid bit at or above ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         valid,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [$clog2(NUM_REQ)-1:0] winner,
   output logic                       found
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   logic [IW-1:0] idx;

   // Scan from the farthest offset down so the nearest hit to ptr wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = IW'((int'(ptr) + i) % NUM_REQ);
         if (valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/ctrl_cfg_arbiter.sv
// Round-robin arbiter that serialises configuration requests into 2-beat
// control packets (header, payload) with an idle gap after each packet.
module ctrl_cfg_arbiter
   import ctrl_pkt_pkg::*;
#(
   parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
   parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned NUM_REQ              = 4,
   parameter int unsigned ENTRY_W              = 256,
   parameter int unsigned GAP_CYCLES           = 2,
   parameter logic [15:0] CTRL_UDP_PORT        = 16'hf2f1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ*8-1:0]                req_mod_id,
   input  logic [NUM_REQ*8-1:0]                req_index,
   input  logic [NUM_REQ*ENTRY_W-1:0]          req_data,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser,
   output logic                                c_m_axis_tvalid,
   output logic                                c_m_axis_tlast,
   input  logic                                c_m_axis_tready,
   output logic                                busy,
   output logic [$clog2(NUM_REQ)-1:0]          grant_id,
   output logic [31:0]                         pkt_cnt
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic [1:0]         state_q, state_d;
   logic [IW-1:0]      rr_ptr_q;
   logic [IW-1:0]      grant_q;
   logic [7:0]         mod_id_q;
   logic [7:0]         index_q;
   logic [ENTRY_W-1:0] data_q;
   logic [GW-1:0]      gap_cnt_q;
   logic [31:0]        pkt_cnt_q;

   logic [IW-1:0]      arb_winner;
   logic               arb_found;
   logic               accept;
   logic               pld_done;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .valid  (req_valid),
      .ptr    (rr_ptr_q),
      .winner (arb_winner),
      .found  (arb_found)
   );

   assign accept   = (state_q == ST_IDLE) && arb_found;
   assign pld_done = (state_q == ST_PLD) && c_m_axis_tready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (arb_found) state_d = ST_HDR;
         ST_HDR:  if (c_m_axis_tready) state_d = ST_PLD;
         ST_PLD:  if (c_m_axis_tready) state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
         ST_GAP:  if (gap_cnt_q == '0) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         mod_id_q  <= '0;
         index_q   <= '0;
         data_q    <= '0;
         gap_cnt_q <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            mod_id_q <= req_mod_id[int'(arb_winner)*8 +: 8];
            index_q  <= req_index[int'(arb_winner)*8 +: 8];
            data_q   <= req_data[int'(arb_winner)*ENTRY_W +: ENTRY_W];
            grant_q  <= arb_winner;
            rr_ptr_q <= (arb_winner == IW'(NUM_REQ - 1)) ? '0 : arb_winner + IW'(1);
         end
         if (pld_done) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            gap_cnt_q <= GAP_LOAD;
         end else if ((state_q == ST_GAP) && (gap_cnt_q != '0)) begin
            gap_cnt_q <= gap_cnt_q - GW'(1);
         end
      end
   end

   // Beats are built from registered state only, so a stalled beat stays bit-stable.
   always_comb begin
      c_m_axis_tdata  = '0;
      c_m_axis_tvalid = 1'b0;
      c_m_axis_tlast  = 1'b0;
      case (state_q)
         ST_HDR: begin
            c_m_axis_tvalid                        = 1'b1;
            c_m_axis_tdata[ETH_TYPE_LSB +: 16]     = ETH_TYPE_VAL;
            c_m_axis_tdata[PROTO_LSB +: 8]         = PROTO_VAL;
            c_m_axis_tdata[UDP_PORT_LSB +: 16]     = CTRL_UDP_PORT;
            c_m_axis_tdata[MOD_ID_LSB +: 8]        = mod_id_q;
            c_m_axis_tdata[RESV_LSB +: 4]          = RESV_VAL;
            c_m_axis_tdata[INDEX_LSB +: 8]         = index_q;
         end
         ST_PLD: begin
            c_m_axis_tvalid                = 1'b1;
            c_m_axis_tlast                 = 1'b1;
            c_m_axis_tdata[ENTRY_W-1:0]    = data_q;
         end
         default: ;
      endcase
   end

   assign req_ready      = (accept && !rst) ? (NUM_REQ'(1) << arb_winner) : '0;
   assign c_m_axis_tkeep = {KW{c_m_axis_tvalid}};
   assign c_m_axis_tuser = '0;
   assign busy           = (state_q != ST_IDLE);
   assign grant_id       = grant_q;
   assign pkt_cnt        = pkt_cnt_q;

endmodule

// File: tb/tb_ctrl_cfg_arbiter.sv
// Randomised bench: two arbiters (gap 2 and gap 0) checked cycle by cycle
// against a transaction-level model of arbitration, beats and gaps.
module tb_ctrl_cfg_arbiter;

   localparam int DW = 512;
   localparam int UW = 128;
   localparam int NR = 4;
   localparam int EW = 256;
   localparam int KW = DW / 8;
   localparam int GAP0 = 2;
   localparam int GAP1 = 0;

   logic clk, rst;
   logic [NR-1:0]    rv    [2];
   logic [NR*8-1:0]  rmod  [2];
   logic [NR*8-1:0]  ridx  [2];
   logic [NR*EW-1:0] rdat  [2];
   logic             trdy  [2];
   logic [NR-1:0]    rrdy  [2];
   logic [DW-1:0]    td    [2];
   logic [KW-1:0]    tk    [2];
   logic [UW-1:0]    tu    [2];
   logic             tv    [2];
   logic             tl    [2];
   logic             bs    [2];
   logic [1:0]       gid   [2];
   logic [31:0]      pc    [2];

   int            checks, errors;
   int            mode;
   int            gap_cfg [2];
   int            m_rr    [2];
   int            m_left  [2];
   int            m_gap   [2];
   int            m_grant [2];
   logic [31:0]   m_cnt   [2];
   logic [DW-1:0] m_hdr   [2];
   logic [DW-1:0] m_pld   [2];
   logic [NR-1:0] taken   [2];

   ctrl_cfg_arbiter #(
      .C_S_AXIS_DATA_WIDTH (DW), .C_S_AXIS_TUSER_WIDTH (UW), .NUM_REQ (NR),
      .ENTRY_W (EW), .GAP_CYCLES (GAP0), .CTRL_UDP_PORT (16'hf2f1)
   ) u_dut_gap2 (
      .clk (clk), .rst (rst), .req_valid (rv[0]), .req_ready (rrdy[0]),
      .req_mod_id (rmod[0]), .req_index (ridx[0]), .req_data (rdat[0]),
      .c_m_axis_tdata (td[0]), .c_m_axis_tkeep (tk[0]), .c_m_axis_tuser (tu[0]),
      .c_m_axis_tvalid (tv[0]), .c_m_axis_tlast (tl[0]), .c_m_axis_tready (trdy[0]),
      .busy (bs[0]), .grant_id (gid[0]), .pkt_cnt (pc[0])
   );

   ctrl_cfg_arbiter #(
      .C_S_AXIS_DATA_WIDTH (DW), .C_S_AXIS_TUSER_WIDTH (UW), .NUM_REQ (NR),
      .ENTRY_W (EW), .GAP_CYCLES (GAP1), .CTRL_UDP_PORT (16'hf2f1)
   ) u_dut_gap0 (
      .clk (clk), .rst (rst), .req_valid (rv[1]), .req_ready (rrdy[1]),
      .req_mod_id (rmod[1]), .req_index (ridx[1]), .req_data (rdat[1]),
      .c_m_axis_tdata (td[1]), .c_m_axis_tkeep (tk[1]), .c_m_axis_tuser (tu[1]),
      .c_m_axis_tvalid (tv[1]), .c_m_axis_tlast (tl[1]), .c_m_axis_tready (trdy[1]),
      .busy (bs[1]), .grant_id (gid[1]), .pkt_cnt (pc[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] hdr(input logic [7:0] m, input logic [7:0] ix);
      logic [DW-1:0] h;
      h = '0;
      h[143:128] = 16'h0008;
      h[223:216] = 8'h11;
      h[335:320] = 16'hf2f1;
      h[375:368] = m;
      h[383:380] = 4'b0001;
      h[391:384] = ix;
      return h;
   endfunction

   task automatic new_req(input int g, input int r);
      rv[g][r] = 1'b1;
      rmod[g][r*8 +: 8] = 8'($urandom);
      ridx[g][r*8 +: 8] = 8'($urandom);
      for (int w = 0; w < EW / 32; w++) rdat[g][r*EW + w*32 +: 32] = $urandom;
   endtask

   task automatic model_reset();
      for (int g = 0; g < 2; g++) begin
         m_rr[g] = 0; m_left[g] = 0; m_gap[g] = 0; m_grant[g] = 0; m_cnt[g] = '0;
         m_hdr[g] = '0; m_pld[g] = '0; taken[g] = '0;
      end
   endtask

   // mode 0: every requester always pending; 1: random; 2: no new requests.
   task automatic drive();
      for (int g = 0; g < 2; g++) begin
         for (int r = 0; r < NR; r++) begin
            if (taken[g][r]) begin
               taken[g][r] = 1'b0;
               if (mode == 0 || (mode == 1 && $urandom_range(1) == 1)) new_req(g, r);
               else rv[g][r] = 1'b0;
            end else if (!rv[g][r] && (mode == 0 || (mode == 1 && $urandom_range(3) == 0))) begin
               new_req(g, r);
            end
         end
         trdy[g] = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
      end
   endtask

   // Predicts what the coming clock edge must do, from the current inputs.
   task automatic model(input int g);
      bit idle, found;
      int w;
      idle = (m_left[g] == 0) && (m_gap[g] == 0);
      check($sformatf("g%0d busy", g), DW'(bs[g]), DW'(!idle));
      check($sformatf("g%0d grant_id", g), DW'(gid[g]), DW'(m_grant[g]));
      check($sformatf("g%0d pkt_cnt", g), DW'(pc[g]), DW'(m_cnt[g]));
      check($sformatf("g%0d tuser", g), DW'(tu[g]), '0);
      if (idle) begin
         found = 0; w = 0;
         for (int k = 0; k < NR; k++) begin
            int c;
            c = (m_rr[g] + k) % NR;
            if (!found && rv[g][c]) begin found = 1; w = c; end
         end
         check($sformatf("g%0d req_ready idle", g), DW'(rrdy[g]), found ? DW'(1) << w : '0);
         check($sformatf("g%0d tvalid idle", g), DW'(tv[g]), '0);
         if (found) begin
            m_hdr[g]   = hdr(rmod[g][w*8 +: 8], ridx[g][w*8 +: 8]);
            m_pld[g]   = DW'(rdat[g][w*EW +: EW]);
            m_left[g]  = 2;
            m_rr[g]    = (w + 1) % NR;
            m_grant[g] = w;
            taken[g][w] = 1'b1;
         end
      end else if (m_left[g] > 0) begin
         check($sformatf("g%0d req_ready busy", g), DW'(rrdy[g]), '0);
         check($sformatf("g%0d tvalid beat", g), DW'(tv[g]), DW'(1));
         check($sformatf("g%0d tdata beat%0d", g, 2 - m_left[g]), td[g],
               (m_left[g] == 2) ? m_hdr[g] : m_pld[g]);
         check($sformatf("g%0d tlast", g), DW'(tl[g]), DW'(m_left[g] == 1));
         check($sformatf("g%0d tkeep", g), DW'(tk[g]), DW'({KW{1'b1}}));
         if (trdy[g]) begin
            m_left[g]--;
            if (m_left[g] == 0) begin
               m_cnt[g]++;
               m_gap[g] = gap_cfg[g];
            end
         end
      end else begin
         check($sformatf("g%0d req_ready gap", g), DW'(rrdy[g]), '0);
         check($sformatf("g%0d tvalid gap", g), DW'(tv[g]), '0);
         m_gap[g]--;
      end
   endtask

   task automatic step();
      @(negedge clk);
      drive();
      #1;
      model(0);
      model(1);
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("%s g%0d tvalid", tag, g), DW'(tv[g]), '0);
         check($sformatf("%s g%0d tdata", tag, g), td[g], '0);
         check($sformatf("%s g%0d tlast", tag, g), DW'(tl[g]), '0);
         check($sformatf("%s g%0d tkeep", tag, g), DW'(tk[g]), '0);
         check($sformatf("%s g%0d busy", tag, g), DW'(bs[g]), '0);
         check($sformatf("%s g%0d grant_id", tag, g), DW'(gid[g]), '0);
         check($sformatf("%s g%0d pkt_cnt", tag, g), DW'(pc[g]), '0);
         check($sformatf("%s g%0d req_ready", tag, g), DW'(rrdy[g]), '0);
      end
   endtask

   initial begin
      bit hit;
      checks = 0; errors = 0; mode = 0;
      gap_cfg[0] = GAP0; gap_cfg[1] = GAP1;
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         rv[g] = '0; rmod[g] = '0; ridx[g] = '0; rdat[g] = '0; trdy[g] = 1'b0;
      end
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      mode = 0;
      repeat (40) step();
      mode = 1;
      repeat (600) step();

      // Mid-packet reset on the gap-2 instance while its payload beat is up.
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(negedge clk);
         drive();
         #1;
         if (m_left[0] == 1) hit = 1;
         else begin
            model(0);
            model(1);
         end
      end
      check("reached payload beat for reset", DW'(hit), DW'(1));
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      for (int g = 0; g < 2; g++) rv[g] = 4'b1000;
      @(negedge clk);
      rst = 1'b0;
      trdy[0] = 1'b1; trdy[1] = 1'b1;
      #1;
      model(0);
      model(1);
      mode = 2;
      repeat (4) step();
      check("post-reset packet count", DW'(pc[0]), DW'(1));
      mode = 1;
      repeat (400) step();
      mode = 0;
      repeat (30) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_cfg_arbiter.md
Name: ctrl_cfg_arbiter

Overview:
Shares the single control AXI-Stream path feeding the action engines' configuration port between NUM_REQ configuration requesters. It round-robin arbitrates requests and serializes each granted request into a 2-beat control packet: a header beat carrying module id, resv and index fields, then a payload beat. After each packet it enforces a programmable gap so the target RAM write can complete before the next packet.

Parameters:
C_S_AXIS_DATA_WIDTH, 512, control stream data width
C_S_AXIS_TUSER_WIDTH, 128, control stream tuser width; driven to zero
NUM_REQ, 4, number of requesters (2..8)
ENTRY_W, 256, payload width per request; must be <= C_S_AXIS_DATA_WIDTH
GAP_CYCLES, 2, idle cycles inserted after each packet (0 = none)
CTRL_UDP_PORT, 16'hf2f1, value placed at header tdata[335:320]

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_mod_id  in  NUM_REQ*8  target module id; slice i belongs to requester i
req_index  in  NUM_REQ*8  target entry index
req_data  in  NUM_REQ*ENTRY_W  entry payload
c_m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  control stream data
c_m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  all ones while tvalid
c_m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  zero
c_m_axis_tvalid  out  1  stream valid
c_m_axis_tlast  out  1  high on payload beat
c_m_axis_tready  in  1  downstream ready
busy  out  1  high in any state other than IDLE
grant_id  out  $clog2(NUM_REQ)  requester of the current or last packet
pkt_cnt  out  32  completed packets, wraps at 2^32

Behaviour:
- Reset (async on rst high): state=IDLE, rr_ptr=0, all outputs 0, latched header and payload 0.
- The FSM has four states: IDLE, HDR, PLD and GAP.
- IDLE, arbitration:
  - Winner is the first requester with req_valid set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[winner]=1 is combinational in IDLE only.
  - On acceptance, latch mod_id, index and data, set grant_id=winner and rr_ptr=(winner+1)%NUM_REQ, then go to HDR.
  - No request: stay in IDLE with req_ready=0.
- HDR: tvalid=1, tlast=0. tdata is zero except:
  - [143:128]=16'h0008
  - [223:216]=8'h11
  - [335:320]=CTRL_UDP_PORT
  - [368+:8]=mod_id
  - [380+:4]=4'b0001
  - [391:384]=index
  On tready go to PLD; otherwise hold every output bit stable.
- PLD: tvalid=1, tlast=1, tdata=payload zero-extended to the LSBs. On tready:
  - pkt_cnt+1
  - next state = GAP if GAP_CYCLES>0, else IDLE
- GAP: down-counter loaded with GAP_CYCLES-1 on entry; tvalid=0, req_ready=0. When the counter reaches 0, go to IDLE on the next cycle, so exactly GAP_CYCLES cycles are spent in GAP.
- Minimum packet-to-packet spacing with tready=1: acceptance cycle, HDR, PLD, GAP_CYCLES, then the next IDLE acceptance. This is 3+GAP_CYCLES cycles per packet.
- Requests are never dropped: req_valid held without ready simply waits. Requester data is sampled only at acceptance; later changes do not affect an in-flight packet.
- Reset asserted mid-packet: the stream is truncated immediately (tvalid=0), the latched request is discarded and the arbiter restarts at requester 0.
- tready high outside HDR/PLD is ignored.

Decomposition:
- Shared package ctrl_pkt_pkg holds the header field offsets (MOD_ID_LSB=368, RESV_LSB=380, INDEX_LSB=384, UDP_PORT_LSB=320, PROTO_LSB=216, ETH_TYPE_LSB=128) and the constants 16'h0008, 8'h11 and 4'b0001.
- One sub-module, rr_arbiter: combinational round-robin winner select from valid and rr_ptr, returning winner index and a found flag.
- The FSM and packet builder stay in ctrl_cfg_arbiter.

Test Plan:
1. Single request: req_valid[2]=1, mod_id=8'h03, index=8'h0f, data=256'hffff, tready=1.
   Required: req_ready[2] pulses one cycle; HDR beat has [368+:8]=03, [391:384]=0f, [335:320]=f2f1; PLD beat=...ffff with tlast=1; pkt_cnt=1; busy low after 2+GAP cycles.
2. Fairness: all four req_valid held high, tready=1, GAP_CYCLES=2.
   Required: grants in order 0,1,2,3,0; packets spaced 5 cycles apart; pkt_cnt=5 after 25 cycles.
3. Backpressure: tready=0 for 3 cycles in HDR and 2 cycles in PLD.
   Required: tdata, tvalid and tlast are bit-identical across stall cycles; no extra beats; pkt_cnt increments once.
4. Sparse rotation: rr_ptr=3 with only req_valid[1] set.
   Required: grant 1 and rr_ptr becomes 2. A request raised during GAP is not accepted until IDLE.
5. Mid-packet reset: assert rst during PLD.
   Required: tvalid=0 asynchronously; pkt_cnt=0 and grant_id=0. After release with req_valid[3]=1, requester 3 is granted and a full packet follows.
6. Zero gap: GAP_CYCLES=0 with two requesters pending.
   Required: packets spaced 3 cycles apart, tkeep all ones and tuser=0 on every beat.
